// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
// Round-robin arbitration is selected by defining ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational picker: first asserted request found when scanning upward
// from start_i, wrapping modulo NUM_REQ.
module arb_priority_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] slot;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        slot    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = IDX_W'((int'(start_i) + i) % NUM_REQ);
            if (!valid_o && req_i[slot]) begin
                idx_o   = slot;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between NUM_REQ cache requesters (IDLE -> WAIT -> DONE).
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index always wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    input  logic                      mem_ready_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [TMR_W-1:0]  timer_q;

    logic [IDX_W-1:0]  pick_start;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic              timed_out;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]  rr_ptr_q;

    // Search begins just past the last winner so every requester gets a turn.
    always_comb begin
        pick_start = (int'(rr_ptr_q) == NUM_REQ - 1) ? '0 : rr_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (state_q == IDLE && pick_valid) begin
            rr_ptr_q <= pick_idx;
        end
    end
`else
    assign pick_start = '0;
`endif

    arb_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .start_i (pick_start),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign timed_out = (timer_q == TMR_LAST);

    // NOTE: sequential blocks use non-blocking (<=); combinational blocks use
    // blocking (=) with every output defaulted first so no latch is inferred.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = WAIT;
            WAIT:    if (mem_ready_i || timed_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready wins over the timeout compare when both land in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        we_q    <= we_i[pick_idx];
                        addr_q  <= addr_i[pick_idx*ADDR_W +: ADDR_W];
                        wdata_q <= wdata_i[pick_idx*DATA_W +: DATA_W];
                        timer_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_ready_i) begin
                        rdata_q <= we_q ? '0 : mem_rdata_i;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req_o = 1'b0;
        busy_o    = 1'b0;
        ack_o     = '0;
        err_o     = 1'b0;
        case (state_q)
            WAIT: begin
                mem_req_o = 1'b1;
                busy_o    = 1'b1;
            end
            DONE: begin
                busy_o         = 1'b1;
                ack_o[grant_q] = 1'b1;
                err_o          = err_q;
            end
            default: ;
        endcase
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign grant_idx_o = grant_q;

endmodule
